// File: rtl/id_stage.sv
// ============================================================================
// Module      : id_stage
// Description : RV32I instruction-decode stage. Holds the IF/ID pipeline
//               register (PC, instruction, valid) under stall/flush/branch
//               control and decodes fields plus the sign-extended immediate.
//               Optional macro ID_ILLEGAL_CHECK_EN: non-RV32I opcodes are
//               reported as bubbles (id_valid=0, imm=0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch,
    input  logic            valid,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    output logic            stall_if,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] imm,
    output logic [6:0]      opcode,
    output logic [4:0]      rd_addr,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [2:0]      func3,
    output logic [6:0]      func7
);

    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    logic [31:0]     ir_q,   ir_d;
    logic [XLEN-1:0] pc_q,   pc_d;
    logic            v_q,    v_d;
    logic [XLEN-1:0] imm_raw;
    logic            op_legal;

    // Kill (flush/branch) outranks stall so a squashed instruction never lingers.
    always_comb begin
        ir_d = ir_q;
        pc_d = pc_q;
        v_d  = v_q;
        if (flush || branch) begin
            ir_d = NOP_INSTR;
            pc_d = '0;
            v_d  = 1'b0;
        end else if (stall) begin
            ir_d = ir_q;
            pc_d = pc_q;
            v_d  = v_q;
        end else if (!valid) begin
            ir_d = NOP_INSTR;
            pc_d = '0;
            v_d  = 1'b0;
        end else begin
            ir_d = instr;
            pc_d = pc;
            v_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            ir_q <= NOP_INSTR;
            pc_q <= '0;
            v_q  <= 1'b0;
        end else begin
            ir_q <= ir_d;
            pc_q <= pc_d;
            v_q  <= v_d;
        end
    end

    always_comb begin
        imm_raw = '0;
        case (ir_q[6:0])
            c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM:
                imm_raw = {{20{ir_q[31]}}, ir_q[31:20]};
            c_OP_STORE:
                imm_raw = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            c_OP_BRANCH:
                imm_raw = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            c_OP_LUI, c_OP_AUIPC:
                imm_raw = {ir_q[31:12], 12'b0};
            c_OP_JAL:
                imm_raw = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:
                imm_raw = '0;
        endcase
    end

`ifdef ID_ILLEGAL_CHECK_EN
    always_comb begin
        op_legal = 1'b0;
        case (ir_q[6:0])
            c_OP_REG, c_OP_IMM, c_OP_LOAD, c_OP_STORE, c_OP_BRANCH, c_OP_JAL,
            c_OP_JALR, c_OP_LUI, c_OP_AUIPC, c_OP_FENCE, c_OP_SYSTEM:
                op_legal = 1'b1;
            default:
                op_legal = 1'b0;
        endcase
    end
`else
    // Without the check every opcode is accepted; R-type stays listed for clarity.
    always_comb begin
        op_legal = 1'b1;
        if (ir_q[6:0] == c_OP_REG) begin
            op_legal = 1'b1;
        end
    end
`endif

    assign stall_if = stall;
    assign id_valid = v_q & op_legal;
    assign id_pc    = pc_q;
    assign imm      = op_legal ? imm_raw : '0;
    assign opcode   = ir_q[6:0];
    assign rd_addr  = ir_q[11:7];
    assign rs1_addr = ir_q[19:15];
    assign rs2_addr = ir_q[24:20];
    assign func3    = ir_q[14:12];
    assign func7    = ir_q[31:25];

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
// Module      : tb_id_stage
// Description : Self-checking bench for id_stage: directed steps followed by
//               randomized stimulus against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_;
    logic        stall, flush, branch, valid;
    logic [31:0] pc, instr;
    logic        stall_if, id_valid;
    logic [31:0] id_pc, imm;
    logic [6:0]  opcode, func7;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr;
    logic [2:0]  func3;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the IF/ID register should hold.
    logic [31:0] m_ir, m_pc;
    logic        m_v;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_(rst_), .stall(stall), .flush(flush), .branch(branch),
        .valid(valid), .pc(pc), .instr(instr), .stall_if(stall_if),
        .id_valid(id_valid), .id_pc(id_pc), .imm(imm), .opcode(opcode),
        .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .func3(func3), .func7(func7)
    );

    function automatic bit is_legal(input logic [6:0] op);
`ifdef ID_ILLEGAL_CHECK_EN
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                          7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
`else
        return 1'b1;
`endif
    endfunction

    // Immediates built from weighted bit values and signed shifts.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int v;
        v = 0;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: v = $signed(i) >>> 20;
            7'h23: v = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
            7'h63: v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048
                       + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            7'h37, 7'h17: v = int'(i & 32'hFFFF_F000);
            7'h6F: v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096
                       + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            default: v = 0;
        endcase
        return is_legal(i[6:0]) ? 32'(v) : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":stall_if"}, {31'b0, stall_if}, {31'b0, stall});
        chk({ctx, ":id_valid"}, {31'b0, id_valid}, {31'b0, m_v & is_legal(m_ir[6:0])});
        chk({ctx, ":id_pc"},    id_pc,  m_pc);
        chk({ctx, ":imm"},      imm,    ref_imm(m_ir));
        chk({ctx, ":fields"},
            {opcode, rd_addr, rs1_addr, rs2_addr, func3, func7},
            {m_ir[6:0], m_ir[11:7], m_ir[19:15], m_ir[24:20], m_ir[14:12], m_ir[31:25]});
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        if (rst_ || flush || branch || (!stall && !valid)) begin
            m_ir = 32'h0; m_pc = 32'h0; m_v = 1'b0;
        end else if (!stall) begin
            m_ir = instr; m_pc = pc; m_v = 1'b1;
        end
        #1;
        check_all(ctx);
    endtask

    task automatic drive(input logic s, input logic f, input logic b, input logic v,
                         input logic [31:0] p, input logic [31:0] i);
        stall = s; flush = f; branch = b; valid = v; pc = p; instr = i;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37,
                7'h17, 7'h0F, 7'h73, 7'h7F};
        return {$urandom() >> 7, ops[$urandom_range(0, 11)]};
    endfunction

    initial begin
        m_ir = '0; m_pc = '0; m_v = 1'b0;
        rst_ = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, $urandom(), $urandom());
        step("reset0");
        drive(1'b0, 1'b0, 1'b0, 1'b1, $urandom(), $urandom());
        step("reset1");
        chk("reset_valid", {31'b0, id_valid}, 32'h0);

        rst_ = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h00A1_0093);
        step("itype");
        chk("itype_valid", {31'b0, id_valid}, 32'h1);
        chk("itype_pc",    id_pc, 32'h1000);
        chk("itype_imm",   imm,   32'h0000_000A);
        chk("itype_regs",  {27'b0, rd_addr, rs1_addr, rs2_addr}, {17'b0, 5'd1, 5'd2, 5'd10});

        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h5555, 32'hDEAD_BEEF);
        #1 chk("stall_if_comb", {31'b0, stall_if}, 32'h1);
        step("stall");
        chk("stall_pc", id_pc, 32'h1000);

        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h3000, 32'h0000_0013);
        step("flush_stall");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h00A1_0093);
        step("reload");
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h3000, 32'h0000_0013);
        step("branch_stall");
        chk("branch_imm", imm, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("bubble");

        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h0010_02EF);
        step("jtype");
        chk("jtype_imm", imm, 32'h0000_0800);
        chk("jtype_rd",  {27'b0, rd_addr}, 32'd5);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h2004, 32'hFFDF_F0EF);
        step("jneg");
        chk("jneg_imm", imm, 32'hFFFF_FFFC);

        // Asynchronous reset between edges.
        #2 rst_ = 1'b1;
        #1;
        m_ir = '0; m_pc = '0; m_v = 1'b0;
        check_all("async_rst");
        rst_ = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h4000, 32'hFE20_8AA3);
        step("after_rst");

        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
                  $urandom() & 32'hFFFF_FFFC, rand_instr());
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
